// File: rtl/regset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : regset_sequencer
// Purpose  : Micro-sequencer for the two-register set (r_0/r_1). Accepts one
//            register-transfer command at a time over valid/ready and expands
//            it into cycle-exact active-low strobes for the register set, the
//            external bus driver, the ALU-result bus driver and the external
//            capture strobe.
// Ports    : i_clk, i_reset          clock, synchronous active-high reset
//            i_cmdValid/o_cmdReady   command handshake
//            i_cmdOp/Src/Dst         command fields (op 0 NOP,1 LOAD,2 READ,
//                                    3 MOV,4 ALU,5-7 illegal)
//            o_ctrlReg*NWE           per-register write enables (active low)
//            o_ctrlReg*BusNOE        per-register bus drive (active low)
//            o_ctrlAluSel            ALU operand select
//            o_extBusNOE/o_aluBusNOE external / ALU bus drivers (active low)
//            o_extCapture            external sink samples bus
//            o_done/o_error          completion / illegal-command pulses
// Revision : 1.0  initial release
// ============================================================================
module regset_sequencer #(
   parameter int BUS_SETTLE  = 1,
   parameter int ALU_LATENCY = 1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_cmdValid,
   output logic       o_cmdReady,
   input  logic [2:0] i_cmdOp,
   input  logic       i_cmdSrc,
   input  logic       i_cmdDst,
   output logic       o_ctrlReg0NWE,
   output logic       o_ctrlReg1NWE,
   output logic       o_ctrlAluSel,
   output logic       o_ctrlReg0BusNOE,
   output logic       o_ctrlReg1BusNOE,
   output logic       o_extBusNOE,
   output logic       o_aluBusNOE,
   output logic       o_extCapture,
   output logic       o_done,
   output logic       o_error
);

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_LOAD = 3'd1;
   localparam logic [2:0] OP_READ = 3'd2;
   localparam logic [2:0] OP_MOV  = 3'd3;
   localparam logic [2:0] OP_ALU  = 3'd4;

   localparam logic [2:0] BS_CNT = 3'(BUS_SETTLE);
   localparam logic [2:0] AL_CNT = 3'(ALU_LATENCY);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ALU_WAIT = 3'd1,
      S_DRIVE    = 3'd2,
      S_XFER     = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t     state, state_n;
   logic [2:0] op_q, op_n;
   logic       src_q, src_n;
   logic       dst_q, dst_n;
   logic       err_q, err_n;
   logic [2:0] cnt, cnt_n;
   logic       alu_sel_n;
   logic       accept;

   // next-cycle strobe values, decoded from the next state and command
   logic       drive_n, reg_drv_n, wr_n;
   logic       reg0_noe_n, reg1_noe_n, ext_noe_n, alu_noe_n;
   logic       reg0_nwe_n, reg1_nwe_n, cap_n, done_n, error_n;

   assign o_cmdReady = (state == S_IDLE) && !i_reset;
   assign accept     = i_cmdValid && o_cmdReady;

   always_comb begin
      state_n   = state;
      op_n      = op_q;
      src_n     = src_q;
      dst_n     = dst_q;
      err_n     = err_q;
      cnt_n     = cnt;
      alu_sel_n = o_ctrlAluSel;
      case (state)
         S_IDLE: begin
            if (accept) begin
               op_n  = i_cmdOp;
               src_n = i_cmdSrc;
               dst_n = i_cmdDst;
               // a register-to-register op onto itself is rejected like an illegal op
               err_n = (i_cmdOp > OP_ALU) ||
                       (((i_cmdOp == OP_MOV) || (i_cmdOp == OP_ALU)) && (i_cmdSrc == i_cmdDst));
               if (err_n || (i_cmdOp == OP_NOP)) begin
                  state_n = S_DONE;
               end else begin
                  if (i_cmdOp == OP_ALU) begin
                     alu_sel_n = i_cmdSrc;
                  end
                  if ((i_cmdOp == OP_ALU) && (AL_CNT != 3'd0)) begin
                     state_n = S_ALU_WAIT;
                     cnt_n   = AL_CNT;
                  end else if (BS_CNT != 3'd0) begin
                     state_n = S_DRIVE;
                     cnt_n   = BS_CNT;
                  end else begin
                     state_n = S_XFER;
                  end
               end
            end
         end
         S_ALU_WAIT: begin
            if (cnt <= 3'd1) begin
               if (BS_CNT != 3'd0) begin
                  state_n = S_DRIVE;
                  cnt_n   = BS_CNT;
               end else begin
                  state_n = S_XFER;
                  cnt_n   = 3'd0;
               end
            end else begin
               cnt_n = cnt - 3'd1;
            end
         end
         S_DRIVE: begin
            if (cnt <= 3'd1) begin
               state_n = S_XFER;
               cnt_n   = 3'd0;
            end else begin
               cnt_n = cnt - 3'd1;
            end
         end
         S_XFER:  state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      drive_n    = (state_n == S_DRIVE) || (state_n == S_XFER);
      reg_drv_n  = drive_n && ((op_n == OP_READ) || (op_n == OP_MOV));
      reg0_noe_n = !(reg_drv_n && !src_n);
      reg1_noe_n = !(reg_drv_n && src_n);
      ext_noe_n  = !(drive_n && (op_n == OP_LOAD));
      alu_noe_n  = !(drive_n && (op_n == OP_ALU));
      wr_n       = (state_n == S_XFER) &&
                   ((op_n == OP_LOAD) || (op_n == OP_MOV) || (op_n == OP_ALU));
      reg0_nwe_n = !(wr_n && !dst_n);
      reg1_nwe_n = !(wr_n && dst_n);
      cap_n      = (state_n == S_XFER) && (op_n == OP_READ);
      done_n     = (state_n == S_DONE);
      error_n    = done_n && err_n;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state            <= S_IDLE;
         op_q             <= OP_NOP;
         src_q            <= 1'b0;
         dst_q            <= 1'b0;
         err_q            <= 1'b0;
         cnt              <= 3'd0;
         o_ctrlAluSel     <= 1'b0;
         o_ctrlReg0NWE    <= 1'b1;
         o_ctrlReg1NWE    <= 1'b1;
         o_ctrlReg0BusNOE <= 1'b1;
         o_ctrlReg1BusNOE <= 1'b1;
         o_extBusNOE      <= 1'b1;
         o_aluBusNOE      <= 1'b1;
         o_extCapture     <= 1'b0;
         o_done           <= 1'b0;
         o_error          <= 1'b0;
      end else begin
         state            <= state_n;
         op_q             <= op_n;
         src_q            <= src_n;
         dst_q            <= dst_n;
         err_q            <= err_n;
         cnt              <= cnt_n;
         o_ctrlAluSel     <= alu_sel_n;
         o_ctrlReg0NWE    <= reg0_nwe_n;
         o_ctrlReg1NWE    <= reg1_nwe_n;
         o_ctrlReg0BusNOE <= reg0_noe_n;
         o_ctrlReg1BusNOE <= reg1_noe_n;
         o_extBusNOE      <= ext_noe_n;
         o_aluBusNOE      <= alu_noe_n;
         o_extCapture     <= cap_n;
         o_done           <= done_n;
         o_error          <= error_n;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regset_sequencer
// Purpose  : Self-checking bench for regset_sequencer. Instance a uses the
//            default parameters and drives a small register-set/bus model;
//            instance b uses ALU_LATENCY=2, BUS_SETTLE=0. Expected per-cycle
//            strobe vectors are queued when a command is issued and popped
//            one per cycle as the DUT runs.
// Vector   : [9]AluSel [8]Reg0NWE [7]Reg1NWE [6]Reg0NOE [5]Reg1NOE
//            [4]extNOE [3]aluNOE [2]capture [1]done [0]error
// Revision : 1.0  initial release
// ============================================================================
module tb_regset_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       a_valid, a_ready, a_src, a_dst;
   logic [2:0] a_op;
   logic       a_nwe0, a_nwe1, a_sel, a_noe0, a_noe1, a_ext, a_alu, a_cap, a_done, a_err;
   logic       b_valid, b_ready, b_src, b_dst;
   logic [2:0] b_op;
   logic       b_nwe0, b_nwe1, b_sel, b_noe0, b_noe1, b_ext, b_alu, b_cap, b_done, b_err;

   regset_sequencer dut_a (
      .i_clk(clk), .i_reset(rst), .i_cmdValid(a_valid), .o_cmdReady(a_ready),
      .i_cmdOp(a_op), .i_cmdSrc(a_src), .i_cmdDst(a_dst),
      .o_ctrlReg0NWE(a_nwe0), .o_ctrlReg1NWE(a_nwe1), .o_ctrlAluSel(a_sel),
      .o_ctrlReg0BusNOE(a_noe0), .o_ctrlReg1BusNOE(a_noe1),
      .o_extBusNOE(a_ext), .o_aluBusNOE(a_alu), .o_extCapture(a_cap),
      .o_done(a_done), .o_error(a_err)
   );

   regset_sequencer #(.BUS_SETTLE(0), .ALU_LATENCY(2)) dut_b (
      .i_clk(clk), .i_reset(rst), .i_cmdValid(b_valid), .o_cmdReady(b_ready),
      .i_cmdOp(b_op), .i_cmdSrc(b_src), .i_cmdDst(b_dst),
      .o_ctrlReg0NWE(b_nwe0), .o_ctrlReg1NWE(b_nwe1), .o_ctrlAluSel(b_sel),
      .o_ctrlReg0BusNOE(b_noe0), .o_ctrlReg1BusNOE(b_noe1),
      .o_extBusNOE(b_ext), .o_aluBusNOE(b_alu), .o_extCapture(b_cap),
      .o_done(b_done), .o_error(b_err)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int acc_cnt  = 0;
   logic checking = 1'b0;
   logic [9:0] exp_q[$];
   logic model_sel_a, model_sel_b;

   // register set + bus environment around instance a; ALU = operand + 1
   logic [7:0] tr0, tr1, ext_data, captured, bus;
   always_comb begin
      bus = 8'h00;
      if (!a_noe0)      bus = tr0;
      else if (!a_noe1) bus = tr1;
      else if (!a_ext)  bus = ext_data;
      else if (!a_alu)  bus = (a_sel ? tr1 : tr0) + 8'h01;
   end
   always @(posedge clk) begin
      if (rst) begin
         tr0 <= 8'h11; tr1 <= 8'h22; captured <= 8'h00;
      end else begin
         if (!a_nwe0) tr0 <= bus;
         if (!a_nwe1) tr1 <= bus;
         if (a_cap)   captured <= bus;
      end
   end

   function automatic logic [9:0] vec_a();
      return {a_sel, a_nwe0, a_nwe1, a_noe0, a_noe1, a_ext, a_alu, a_cap, a_done, a_err};
   endfunction
   function automatic logic [9:0] vec_b();
      return {b_sel, b_nwe0, b_nwe1, b_noe0, b_noe1, b_ext, b_alu, b_cap, b_done, b_err};
   endfunction

   // invariants and acceptance counting, sampled mid-cycle
   always @(negedge clk) begin
      if (checking) begin
         n_checks++;
         if (($countones({~a_noe0, ~a_noe1, ~a_ext, ~a_alu}) > 1) || (!a_nwe0 && !a_nwe1) ||
             (a_done && ({a_nwe0, a_nwe1, a_noe0, a_noe1, a_ext, a_alu} != 6'h3F || a_cap))) begin
            n_fail++;
            $display("FAIL invariant_a: got %b", vec_a());
         end
         n_checks++;
         if (($countones({~b_noe0, ~b_noe1, ~b_ext, ~b_alu}) > 1) || (!b_nwe0 && !b_nwe1) ||
             (b_done && ({b_nwe0, b_nwe1, b_noe0, b_noe1, b_ext, b_alu} != 6'h3F || b_cap))) begin
            n_fail++;
            $display("FAIL invariant_b: got %b", vec_b());
         end
      end
      if (a_valid && a_ready) acc_cnt++;
   end

   // reference expansion of one command into per-cycle strobe vectors
   task automatic push_exp(input logic [2:0] op, input logic src, input logic dst,
                           input int al, input int bs, inout logic sel, output int n);
      logic       err;
      logic [9:0] base, drv, x;
      err = (op > 3'd4) || (((op == 3'd3) || (op == 3'd4)) && (src == dst));
      if ((op == 3'd4) && !err) sel = src;
      base = {sel, 6'b111111, 3'b000};
      n = 0;
      if ((op == 3'd0) || err) begin
         x = base; x[1] = 1'b1; x[0] = err;
         exp_q.push_back(x); n = 1;
      end else begin
         drv = base;
         case (op)
            3'd1:    drv[4] = 1'b0;
            3'd4:    drv[3] = 1'b0;
            default: drv[src ? 5 : 6] = 1'b0;
         endcase
         if (op == 3'd4) begin
            for (int i = 0; i < al; i++) begin exp_q.push_back(base); n++; end
         end
         for (int i = 0; i < bs; i++) begin exp_q.push_back(drv); n++; end
         x = drv;
         if (op == 3'd2) x[2] = 1'b1;
         else            x[dst ? 7 : 8] = 1'b0;
         exp_q.push_back(x); n++;
         x = base; x[1] = 1'b1;
         exp_q.push_back(x); n++;
      end
   endtask

   task automatic send_a(input logic [2:0] op, input logic src, input logic dst);
      int i;
      a_op = op; a_src = src; a_dst = dst; a_valid = 1'b1;
      i = 0;
      while (!a_ready && i < 20) begin @(negedge clk); i++; end
      n_checks++;
      if (!a_ready) begin n_fail++; $display("FAIL accept_timeout_a: ready=%b required 1", a_ready); end
      @(posedge clk); #1 a_valid = 1'b0;
   endtask

   task automatic send_b(input logic [2:0] op, input logic src, input logic dst);
      int i;
      b_op = op; b_src = src; b_dst = dst; b_valid = 1'b1;
      i = 0;
      while (!b_ready && i < 20) begin @(negedge clk); i++; end
      n_checks++;
      if (!b_ready) begin n_fail++; $display("FAIL accept_timeout_b: ready=%b required 1", b_ready); end
      @(posedge clk); #1 b_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] idle;
      idle = {1'b0, 6'b111111, 3'b000};
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checking = 1'b1;
      n_checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: a=%b b=%b required 0", a_ready, b_ready);
      end
      n_checks++;
      if (vec_a() !== idle || vec_b() !== idle) begin
         n_fail++; $display("FAIL reset_strobes: a=%b b=%b required %b", vec_a(), vec_b(), idle);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: a=%b b=%b required 1", a_ready, b_ready);
      end
      model_sel_a = 1'b0; model_sel_b = 1'b0;
   endtask

   task automatic test_load();
      int n; logic [9:0] e;
      ext_data = 8'h5A;
      send_a(3'd1, 1'b0, 1'b1);
      push_exp(3'd1, 1'b0, 1'b1, 1, 1, model_sel_a, n);
      repeat (n) begin
         @(negedge clk); e = exp_q.pop_front(); n_checks++;
         if (vec_a() !== e) begin n_fail++; $display("FAIL load_strobes: got %b required %b", vec_a(), e); end
      end
      n_checks++;
      if (tr1 !== 8'h5A) begin n_fail++; $display("FAIL load_r1: got %h required 5a", tr1); end
   endtask

   task automatic test_mov();
      int n; logic [9:0] e;
      send_a(3'd3, 1'b1, 1'b0);
      push_exp(3'd3, 1'b1, 1'b0, 1, 1, model_sel_a, n);
      repeat (n) begin
         @(negedge clk); e = exp_q.pop_front(); n_checks++;
         if (vec_a() !== e) begin n_fail++; $display("FAIL mov_strobes: got %b required %b", vec_a(), e); end
      end
      n_checks++;
      if (tr0 !== 8'h5A) begin n_fail++; $display("FAIL mov_r0: got %h required 5a", tr0); end
   endtask

   task automatic test_alu_param();
      int n; logic [9:0] e;
      send_b(3'd4, 1'b1, 1'b0);
      push_exp(3'd4, 1'b1, 1'b0, 2, 0, model_sel_b, n);
      repeat (n) begin
         @(negedge clk); e = exp_q.pop_front(); n_checks++;
         if (vec_b() !== e) begin n_fail++; $display("FAIL alu_b_strobes: got %b required %b", vec_b(), e); end
      end
      repeat (2) begin
         @(negedge clk); n_checks++;
         if (b_sel !== 1'b1) begin n_fail++; $display("FAIL alu_b_sel_hold: got %b required 1", b_sel); end
      end
   endtask

   task automatic test_read_illegal();
      int n; logic [9:0] e;
      send_a(3'd2, 1'b0, 1'b1);
      push_exp(3'd2, 1'b0, 1'b1, 1, 1, model_sel_a, n);
      repeat (n) begin
         @(negedge clk); e = exp_q.pop_front(); n_checks++;
         if (vec_a() !== e) begin n_fail++; $display("FAIL read_strobes: got %b required %b", vec_a(), e); end
      end
      n_checks++;
      if (captured !== 8'h5A) begin n_fail++; $display("FAIL read_capture: got %h required 5a", captured); end
      send_a(3'd6, 1'b0, 1'b1);
      push_exp(3'd6, 1'b0, 1'b1, 1, 1, model_sel_a, n);
      repeat (n) begin
         @(negedge clk); e = exp_q.pop_front(); n_checks++;
         if (vec_a() !== e) begin n_fail++; $display("FAIL illegal_strobes: got %b required %b", vec_a(), e); end
      end
   endtask

   task automatic test_mov_same();
      int n; logic [9:0] e;
      send_a(3'd3, 1'b0, 1'b0);
      push_exp(3'd3, 1'b0, 1'b0, 1, 1, model_sel_a, n);
      repeat (n) begin
         @(negedge clk); e = exp_q.pop_front(); n_checks++;
         if (vec_a() !== e) begin n_fail++; $display("FAIL mov_same_strobes: got %b required %b", vec_a(), e); end
      end
      send_a(3'd0, 1'b1, 1'b0);
      push_exp(3'd0, 1'b1, 1'b0, 1, 1, model_sel_a, n);
      repeat (n) begin
         @(negedge clk); e = exp_q.pop_front(); n_checks++;
         if (vec_a() !== e) begin n_fail++; $display("FAIL nop_strobes: got %b required %b", vec_a(), e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] ops[3]  = '{3'd1, 3'd4, 3'd2};
      logic       srcs[3] = '{1'b0, 1'b0, 1'b1};
      logic       dsts[3] = '{1'b0, 1'b1, 1'b0};
      int n, i, acc0; logic [9:0] e;
      ext_data = 8'h3C;
      acc0 = acc_cnt;
      a_op = ops[0]; a_src = srcs[0]; a_dst = dsts[0]; a_valid = 1'b1;
      i = 0;
      while (!a_ready && i < 20) begin @(negedge clk); i++; end
      @(posedge clk); #1;
      a_op = ops[1]; a_src = srcs[1]; a_dst = dsts[1];
      for (int c = 0; c < 3; c++) begin
         push_exp(ops[c], srcs[c], dsts[c], 1, 1, model_sel_a, n);
         repeat (n) begin
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (vec_a() !== e) begin n_fail++; $display("FAIL b2b_strobes cmd%0d: got %b required %b", c, vec_a(), e); end
         end
         if (c < 2) begin
            @(negedge clk); n_checks++;
            if (a_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready cmd%0d: got %b required 1", c, a_ready); end
            @(posedge clk); #1;
            if (c == 0) begin a_op = ops[2]; a_src = srcs[2]; a_dst = dsts[2]; end
            else        a_valid = 1'b0;
         end
      end
      n_checks++;
      if (acc_cnt - acc0 !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d required 3", acc_cnt - acc0); end
      n_checks++;
      if (tr1 !== 8'h3D || captured !== 8'h3D) begin
         n_fail++; $display("FAIL b2b_data: r1=%h cap=%h required 3d", tr1, captured);
      end
   endtask

   task automatic test_reset_mid();
      logic [9:0] e;
      ext_data = 8'h77;
      send_a(3'd1, 1'b0, 1'b1);
      @(negedge clk);
      e = {model_sel_a, 6'b111111, 3'b000}; e[4] = 1'b0; n_checks++;
      if (vec_a() !== e) begin n_fail++; $display("FAIL mid_drive: got %b required %b", vec_a(), e); end
      rst = 1'b1;
      @(negedge clk);
      model_sel_a = 1'b0;
      e = {1'b0, 6'b111111, 3'b000}; n_checks++;
      if (vec_a() !== e || a_ready !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: got %b ready=%b required %b ready=0", vec_a(), a_ready, e);
      end
      rst = 1'b0;
      @(negedge clk); n_checks++;
      if (vec_a() !== e || a_ready !== 1'b1) begin
         n_fail++; $display("FAIL mid_release: got %b ready=%b required %b ready=1", vec_a(), a_ready, e);
      end
      @(negedge clk); n_checks++;
      if (vec_a() !== e || tr1 !== 8'h22) begin
         n_fail++; $display("FAIL mid_no_finish: got %b r1=%h required %b r1=22", vec_a(), tr1, e);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_valid = 1'b0; a_op = 3'd0; a_src = 1'b0; a_dst = 1'b0;
      b_valid = 1'b0; b_op = 3'd0; b_src = 1'b0; b_dst = 1'b0;
      ext_data = 8'h00;
      test_reset();
      test_load();
      test_mov();
      test_alu_param();
      test_read_illegal();
      test_mov_same();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/regset_sequencer.md
Name: regset_sequencer

Overview:
- Micro-sequencer for the two-register set (r_0/r_1).
- Accepts one register-transfer command at a time over a valid/ready handshake.
- Expands each command into the cycle-exact active-low control strobes for the register set: per-register write enables, per-register bus output enables and the ALU operand select.
- Also drives the enables for the external bus driver, the ALU-result bus driver and the external capture strobe. Sits between the instruction decoder and the register set.

Parameters:
BUS_SETTLE, 1, drive cycles on bus before the write/capture cycle (0..7)
ALU_LATENCY, 1, cycles AluSel is held before the ALU result is driven onto the bus (0..7)

Ports:
i_clk  input  1  clock
i_reset  input  1  synchronous active-high reset
i_cmdValid  input  1  command valid
o_cmdReady  output  1  sequencer can accept a command
i_cmdOp  input  3  0 NOP, 1 LOAD, 2 READ, 3 MOV, 4 ALU, 5-7 illegal
i_cmdSrc  input  1  source register index
i_cmdDst  input  1  destination register index
o_ctrlReg0NWE  output  1  r_0 write enable, active low
o_ctrlReg1NWE  output  1  r_1 write enable, active low
o_ctrlAluSel  output  1  ALU operand select (0 = r_0, 1 = r_1)
o_ctrlReg0BusNOE  output  1  r_0 bus drive, active low
o_ctrlReg1BusNOE  output  1  r_1 bus drive, active low
o_extBusNOE  output  1  external data source drives bus, active low
o_aluBusNOE  output  1  ALU result drives bus, active low
o_extCapture  output  1  external sink samples bus this cycle
o_done  output  1  one-cycle completion pulse
o_error  output  1  one-cycle pulse alongside o_done for an illegal command

Behaviour:
- States: IDLE, ALU_WAIT, DRIVE, XFER, DONE.
- o_cmdReady = 1 only in IDLE and only when i_reset = 0. A command is accepted on a clock edge where valid & ready; op/src/dst are registered at acceptance.
- Acceptance in IDLE:
  - ALU -> ALU_WAIT, or DRIVE if ALU_LATENCY = 0, or XFER if both parameters are 0.
  - LOAD/READ/MOV -> DRIVE, or XFER if BUS_SETTLE = 0.
  - NOP, illegal op, or MOV/ALU with src == dst -> DONE directly with no strobes.
- ALU_WAIT: lasts ALU_LATENCY cycles. AluSel = src.
- DRIVE: lasts BUS_SETTLE cycles. The bus driver is asserted:
  - LOAD: ext
  - READ/MOV: reg[src]
  - ALU: alu
- XFER: exactly 1 cycle. The same driver stays asserted, plus:
  - LOAD/MOV/ALU: NWE[dst] low
  - READ: o_extCapture = 1
- DONE: 1 cycle. o_done = 1; o_error = 1 for illegal op or src == dst. Next state is IDLE.
- o_ctrlAluSel is a register: loaded with src when an ALU command is accepted, held through completion and afterwards until the next ALU command.
- Counters: one 3-bit down-counter shared by ALU_WAIT and DRIVE, loaded on entry to each state.
- All strobe outputs are registered (decoded from next-state); no combinational path from command inputs to strobes.
- Invariants, checked every cycle:
  - at most one of {Reg0BusNOE, Reg1BusNOE, extBusNOE, aluBusNOE} is low;
  - at most one NWE is low;
  - NWE is low only in XFER;
  - no strobe is asserted in IDLE or DONE.
- Reset, including mid-command: on the edge with i_reset = 1, state returns to IDLE, the command is discarded, all NOE/NWE go high, AluSel = 0, o_extCapture/o_done/o_error = 0, counter = 0. o_cmdReady = 0 while i_reset is high, and 1 on the first cycle after reset deasserts.
- Latency (defaults) from the acceptance edge to o_done: NOP 1 cycle; LOAD/READ/MOV 3 cycles; ALU 4 cycles. Next command accepted one cycle after o_done.
- i_cmdValid held high while busy: no effect; the command is accepted on the first IDLE cycle.

Test Plan:
- Reset, then LOAD dst=1 with ext bus = 0x5A (defaults) -> extBusNOE low for cycles 1-2, Reg1NWE low only in cycle 2, o_done in cycle 3, r_1 = 0x5A.
- MOV src=1 dst=0 -> Reg1BusNOE low for 2 cycles, Reg0NWE low in the 2nd cycle, r_0 = 0x5A, no other driver low.
- ALU src=1 dst=0 with ALU_LATENCY = 2, BUS_SETTLE = 0 -> AluSel = 1 for cycles 1-2, aluBusNOE + Reg0NWE low in cycle 3, o_done in cycle 4, AluSel still 1 afterwards.
- READ src=0 -> Reg0BusNOE low 2 cycles, o_extCapture = 1 only in the 2nd; illegal op 6 -> no strobes, o_done = o_error = 1 one cycle after acceptance.
- MOV src=0 dst=0 -> o_error pulse, no NWE; back-to-back valid held high -> exactly one acceptance per command, bus one-hot invariant never violated.
- Assert i_reset during DRIVE of a LOAD -> all strobes high the next cycle, no NWE pulse, no o_done, o_cmdReady = 1 the cycle after reset drops.
